// File: rtl/bit_population_counter_mc.sv
// Multi-cycle handshaked population counter: latches one word, sums CHUNK bits per cycle.
// Optional BIT_POPULATION_COUNTER_MC_PARITY_EN adds parity_o (LSB of the registered count).
module bit_population_counter_mc #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     data_val_i,
    output logic                     data_ready_o,
    input  logic                     invert_i,
    output logic [$clog2(WIDTH):0]   data_o,
    output logic                     data_val_o,
    input  logic                     data_ready_i
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
    ,
    output logic                     parity_o
`endif
);

    localparam int N_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PAD_W    = N_CHUNKS * CHUNK;
    localparam int CNT_W    = $clog2(WIDTH) + 1;
    localparam int SUM_W    = $clog2(CHUNK) + 1;
    localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   shadow_q, shadow_d;
    logic [PAD_W-1:0]   shifted;
    logic [CHUNK-1:0]   chunk;
    logic [SUM_W-1:0]   chunk_sum;
    logic [CNT_W-1:0]   acc_q, acc_next;
    logic [CNT_W-1:0]   result_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   word_in;
    logic               last_chunk;
    logic               in_xfer;

    assign in_xfer    = data_val_i && data_ready_o;
    assign last_chunk = (idx_q == IDX_W'(N_CHUNKS - 1));
    assign word_in    = invert_i ? ~data_i : data_i;

    // Padding above WIDTH is zero-filled after inversion so it is never counted.
    always_comb begin
        shadow_d = '0;
        shadow_d[WIDTH-1:0] = word_in;
    end

    // NOTE: blocking assignments in combinational logic let the loop accumulate in order.
    always_comb begin
        shifted   = shadow_q >> (int'(idx_q) * CHUNK);
        chunk     = shifted[CHUNK-1:0];
        chunk_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum = chunk_sum + SUM_W'(chunk[i]);
        end
        acc_next = acc_q + CNT_W'(chunk_sum);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        data_ready_o = 1'b0;
        data_val_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                data_ready_o = 1'b1;
                if (data_val_i) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (last_chunk) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                data_val_o = 1'b1;
                if (data_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shadow word is pure datapath, always loaded before use, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && in_xfer) begin
            shadow_q <= shadow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                COUNT: begin
                    acc_q <= acc_next;
                    idx_q <= idx_q + 1'b1;
                    if (last_chunk) begin
                        result_q <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o = result_q;

`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
    // The count's LSB is the XOR of the counted bits.
    assign parity_o = result_q[0];
`endif

endmodule

// File: tb/tb_bit_population_counter_mc.sv
// Self-checking bench for bit_population_counter_mc: directed scenarios plus randomized streams
// against a popcount reference model; covers 32/8, 10/4 (partial chunk) and 16/16 configurations.
module tb_bit_population_counter_mc;

    localparam int QW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          srst;
    logic [31:0]   d;
    logic          dv, drdy, inv, qv, qrdy;
    logic [QW-1:0] q;

    logic [9:0]    d10;
    logic          dv10, drdy10, inv10, qv10;
    logic          qrdy10 = 1'b1;
    logic [4:0]    q10;

    logic [15:0]   d16;
    logic          dv16, drdy16, inv16, qv16;
    logic          qrdy16 = 1'b1;
    logic [4:0]    q16;

`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
    logic par, par10, par16;
`endif

    bit_population_counter_mc #(.WIDTH(32), .CHUNK(8)) dut (
        .clk_i(clk), .srst_i(srst), .data_i(d), .data_val_i(dv), .data_ready_o(drdy),
        .invert_i(inv), .data_o(q), .data_val_o(qv), .data_ready_i(qrdy)
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        , .parity_o(par)
`endif
    );

    bit_population_counter_mc #(.WIDTH(10), .CHUNK(4)) dut10 (
        .clk_i(clk), .srst_i(srst), .data_i(d10), .data_val_i(dv10), .data_ready_o(drdy10),
        .invert_i(inv10), .data_o(q10), .data_val_o(qv10), .data_ready_i(qrdy10)
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        , .parity_o(par10)
`endif
    );

    bit_population_counter_mc #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk_i(clk), .srst_i(srst), .data_i(d16), .data_val_i(dv16), .data_ready_o(drdy16),
        .invert_i(inv16), .data_o(q16), .data_val_o(qv16), .data_ready_i(qrdy16)
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        , .parity_o(par16)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] stim_w[$];
    logic        stim_i[$];

    // Waits for the main DUT result; k = cycles from accept edge to data_val_o.
    task automatic wait_main(output int k);
        k = 0;
        @(negedge clk);
        dv = 1'b0;
        while (!qv && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; dv = 1'b0; d = '0; inv = 1'b0; qrdy = 1'b1;
        dv10 = 1'b0; d10 = '0; inv10 = 1'b0;
        dv16 = 1'b0; d16 = '0; inv16 = 1'b0;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        checks++; if (drdy !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", drdy); end
        checks++; if (qv !== 1'b0)   begin failures++; $display("FAIL reset_val: got %b want 0", qv); end
        checks++; if (q !== '0)      begin failures++; $display("FAIL reset_data: got %0d want 0", q); end
        checks++; if (drdy10 !== 1'b1 || qv10 !== 1'b0 || q10 !== '0)
            begin failures++; $display("FAIL reset_dut10: ready=%b val=%b data=%0d want 1 0 0", drdy10, qv10, q10); end
        checks++; if (drdy16 !== 1'b1 || qv16 !== 1'b0 || q16 !== '0)
            begin failures++; $display("FAIL reset_dut16: ready=%b val=%b data=%0d want 1 0 0", drdy16, qv16, q16); end
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        checks++; if (par !== 1'b0) begin failures++; $display("FAIL reset_parity: got %b want 0", par); end
`endif
    endtask

    task automatic test_full_ones();
        int k;
        d = 32'hFFFF_FFFF; inv = 1'b0; qrdy = 1'b1; dv = 1'b1;
        checks++; if (drdy !== 1'b1) begin failures++; $display("FAIL ones_accept_ready: got %b want 1", drdy); end
        wait_main(k);
        checks++; if (k !== 4)     begin failures++; $display("FAIL ones_latency: got %0d want 4", k); end
        checks++; if (q !== 6'd32) begin failures++; $display("FAIL ones_data: got %0d want 32", q); end
        checks++; if (drdy !== 1'b0) begin failures++; $display("FAIL ones_ready_in_done: got %b want 0", drdy); end
        @(negedge clk);
        checks++; if (qv !== 1'b0 || drdy !== 1'b1)
            begin failures++; $display("FAIL ones_return_idle: val=%b ready=%b want 0 1", qv, drdy); end
    endtask

    task automatic test_stall();
        int k;
        d = 32'h8000_0001; inv = 1'b0; qrdy = 1'b0; dv = 1'b1;
        wait_main(k);
        checks++; if (k !== 4 || q !== 6'd2)
            begin failures++; $display("FAIL stall_result: latency=%0d data=%0d want 4 2", k, q); end
        repeat (5) begin
            @(negedge clk);
            checks++; if (qv !== 1'b1 || q !== 6'd2 || drdy !== 1'b0)
                begin failures++; $display("FAIL stall_hold: val=%b data=%0d ready=%b want 1 2 0", qv, q, drdy); end
        end
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        checks++; if (par !== 1'b0) begin failures++; $display("FAIL stall_parity: got %b want 0", par); end
`endif
        qrdy = 1'b1;
        @(negedge clk);
        checks++; if (qv !== 1'b0 || drdy !== 1'b1)
            begin failures++; $display("FAIL stall_release: val=%b ready=%b want 0 1", qv, drdy); end
        checks++; if (q !== 6'd2) begin failures++; $display("FAIL stall_retain: got %0d want 2", q); end
    endtask

    task automatic test_reset_mid_count();
        int k;
        bit saw_val = 1'b0;
        d = 32'hFFFF_FFFF; inv = 1'b0; qrdy = 1'b1; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        repeat (2) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        checks++; if (drdy !== 1'b1 || qv !== 1'b0 || q !== '0)
            begin failures++; $display("FAIL midreset_state: ready=%b val=%b data=%0d want 1 0 0", drdy, qv, q); end
        repeat (6) begin
            @(negedge clk);
            if (qv) saw_val = 1'b1;
        end
        checks++; if (saw_val !== 1'b0) begin failures++; $display("FAIL midreset_no_result: got val want none"); end
        d = 32'h0000_0003; dv = 1'b1;
        wait_main(k);
        checks++; if (k !== 4 || q !== 6'd2)
            begin failures++; $display("FAIL midreset_next: latency=%0d data=%0d want 4 2", k, q); end
        @(negedge clk);
    endtask

    // Streams stim_w/stim_i through the main DUT and scores results against popcount of each word.
    task automatic run_stream(input string name, input int stall_pct, input int gap_pct, input bit hold_val);
        int          exp_q[$];
        int          n_exp, got, cyc, e;
        bit          prev_hold;
        logic [QW-1:0] prev_q;
        n_exp = stim_w.size(); got = 0; cyc = 0; prev_hold = 1'b0; prev_q = '0;
        while (got < n_exp && cyc < 4000) begin
            checks++; if (drdy && qv) begin failures++; $display("FAIL %s_overlap: ready=1 val=1 want exclusive", name); end
            if (prev_hold) begin
                checks++; if (qv !== 1'b1 || q !== prev_q)
                    begin failures++; $display("FAIL %s_hold: val=%b data=%0d want 1 %0d", name, qv, q, prev_q); end
            end
            qrdy = ($urandom_range(99) >= stall_pct);
            if (qv && qrdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL %s_extra: got result %0d want none", name, q);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (q !== QW'(e)) begin failures++; $display("FAIL %s_data: got %0d want %0d", name, q, e); end
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
                    checks++; if (par !== e[0]) begin failures++; $display("FAIL %s_parity: got %b want %b", name, par, e[0]); end
`endif
                end
            end
            prev_hold = qv && !qrdy;
            prev_q    = q;
            if (drdy && stim_w.size() > 0 && $urandom_range(99) >= gap_pct) begin
                d   = stim_w.pop_front();
                inv = stim_i.pop_front();
                dv  = 1'b1;
                exp_q.push_back($countones(inv ? ~d : d));
            end else begin
                dv  = drdy ? 1'b0 : (hold_val ? 1'b1 : 1'($urandom_range(1)));
                d   = $urandom;
                inv = 1'($urandom_range(1));
            end
            @(negedge clk);
            cyc++;
        end
        dv = 1'b0; qrdy = 1'b1;
        checks++; if (got !== n_exp) begin failures++; $display("FAIL %s_timeout: got %0d results want %0d", name, got, n_exp); end
        @(negedge clk);
        checks++; if (qv !== 1'b0) begin failures++; $display("FAIL %s_drain: val=%b want 0", name, qv); end
    endtask

    task automatic test_back_to_back();
        stim_w = {32'h0000_00F0, 32'h0F0F_0F0F};
        stim_i = {1'b0, 1'b0};
        run_stream("b2b", 0, 0, 1'b1);
    endtask

    task automatic test_random_stream();
        stim_w.delete(); stim_i.delete();
        for (int i = 0; i < 40; i++) begin
            stim_w.push_back((i == 0) ? 32'h0 : $urandom);
            stim_i.push_back((i == 1) ? 1'b1 : 1'($urandom_range(1)));
        end
        run_stream("rand", 40, 30, 1'b0);
    endtask

    task automatic xact10(input logic [9:0] w, input logic iv);
        int k;
        int e;
        logic [9:0] m;
        m = iv ? ~w : w;
        e = $countones(m);
        d10 = w; inv10 = iv; dv10 = 1'b1;
        checks++; if (drdy10 !== 1'b1) begin failures++; $display("FAIL partial_ready: got %b want 1", drdy10); end
        k = 0;
        @(negedge clk);
        dv10 = 1'b0; d10 = 10'($urandom); inv10 = ~iv;
        while (!qv10 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k !== 3 || q10 !== 5'(e))
            begin failures++; $display("FAIL partial_result: w=%h inv=%b latency=%0d data=%0d want 3 %0d", w, iv, k, q10, e); end
        @(negedge clk);
    endtask

    task automatic test_partial_chunk();
        xact10(10'h3FF, 1'b0);
        xact10(10'h000, 1'b1);
        for (int i = 0; i < 8; i++) xact10(10'($urandom), 1'($urandom_range(1)));
    endtask

    task automatic xact16(input logic [15:0] w, input logic iv);
        int k;
        int e;
        logic [15:0] m;
        m = iv ? ~w : w;
        e = $countones(m);
        d16 = w; inv16 = iv; dv16 = 1'b1;
        k = 0;
        @(negedge clk);
        dv16 = 1'b0;
        while (!qv16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k !== 1 || q16 !== 5'(e))
            begin failures++; $display("FAIL single_result: w=%h inv=%b latency=%0d data=%0d want 1 %0d", w, iv, k, q16, e); end
`ifdef BIT_POPULATION_COUNTER_MC_PARITY_EN
        checks++; if (par16 !== e[0]) begin failures++; $display("FAIL single_parity: got %b want %b", par16, e[0]); end
`endif
        @(negedge clk);
    endtask

    task automatic test_single_chunk();
        xact16(16'hAAAA, 1'b0);
        xact16(16'h0007, 1'b0);
        for (int i = 0; i < 6; i++) xact16(16'($urandom), 1'($urandom_range(1)));
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_full_ones();
        test_stall();
        test_reset_mid_count();
        test_back_to_back();
        test_random_stream();
        test_partial_chunk();
        test_single_chunk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_population_counter_mc.md
Name: bit_population_counter_mc

Overview:
Multi-cycle, handshaked population counter; the successor to the single-shot counter.
- Latches one WIDTH-bit word on a valid/ready handshake.
- Sums CHUNK bits per cycle, so area scales with CHUNK, not WIDTH.
- Presents the count with valid/ready backpressure.
- Runtime mode counts ones or zeros.
- Sits between a streaming producer and a consumer that may stall.

Parameters:
- WIDTH, 32, input word width in bits; must be >= 1.
- CHUNK, 8, bits summed per cycle; 1 <= CHUNK <= WIDTH; need not divide WIDTH.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- srst_i  input  1  reset; synchronous and active-high.
- data_i  input  WIDTH  word to count.
- data_val_i  input  1  data_i and invert_i are valid.
- data_ready_o  output  1  block can accept a word.
- invert_i  input  1  0 = count ones, 1 = count zeros; sampled with data_i.
- data_o  output  $clog2(WIDTH)+1  population count result.
- data_val_o  output  1  data_o is valid.
- data_ready_i  input  1  consumer accepts data_o.

Behaviour:
- Derived constant: N_CHUNKS = ceil(WIDTH/CHUNK). Latency from accept to data_val_o = N_CHUNKS cycles.
- Handshakes:
  - Input transfer when data_val_i && data_ready_o on a rising edge.
  - Output transfer when data_val_o && data_ready_i on a rising edge.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - data_ready_o=1, data_val_o=0.
  - On input transfer: latch data_i into shadow register, bitwise inverted if invert_i=1.
  - Clear accumulator and chunk index; go to COUNT.
- COUNT:
  - data_ready_o=0, data_val_o=0.
  - Each cycle add the popcount of shadow[idx*CHUNK +: CHUNK] to the accumulator.
  - Bit positions >= WIDTH in the final partial chunk are forced to 0, including in invert mode, so padding is never counted.
  - idx increments each cycle.
  - On the cycle idx == N_CHUNKS-1: register accumulator + chunk sum into data_o and go to DONE.
- DONE:
  - data_val_o=1; data_o is held stable while data_ready_i=0, for an unbounded number of cycles.
  - On output transfer: go to IDLE.
  - data_ready_o stays 0 in DONE; no overlap of result and next accept. A new word is accepted earliest 1 cycle after the output transfer.
- data_val_i and data_i changing while data_ready_o=0 are ignored.
- Width rules:
  - Accumulator and data_o are $clog2(WIDTH)+1 bits; the maximum value WIDTH fits without overflow.
  - Chunk sum is $clog2(CHUNK)+1 bits, zero-extended before the add.
- data_o retains its last result after returning to IDLE until the next DONE overwrites it.
- Reset values: state=IDLE, data_ready_o=1 in the cycle after reset, data_val_o=0, data_o=0, accumulator=0, idx=0.
- Reset mid-operation (COUNT or DONE): the in-flight word is discarded, no data_val_o is produced, and the block returns to IDLE next cycle.
- Reset has priority over any simultaneous handshake.
- CHUNK == WIDTH is a legal degenerate case: N_CHUNKS=1, result valid 1 cycle after accept.

Optional Feature:
- Macro: BIT_POPULATION_COUNTER_MC_PARITY_EN
- Defined:
  - Adds output port parity_o (1 bit) = data_o[0], i.e. XOR parity of the counted bits, after inversion if invert_i=1.
  - Registered together with data_o; valid and held under the same data_val_o/data_ready_i rules; reset value 0.
- Undefined: the port does not exist and there is no extra logic.

Test Plan:
- WIDTH=32, CHUNK=8, data_i=0xFFFF_FFFF, invert_i=0, data_ready_i=1, accept at cycle T -> data_val_o=1 at T+4 with data_o=32; data_ready_o=1 again at T+5.
- WIDTH=10, CHUNK=4 (partial chunk), data_i=0x3FF -> data_o=10 at T+3; then data_i=0x000 with invert_i=1 -> data_o=10 (padding bits 10..11 not counted).
- WIDTH=32, CHUNK=8, data_i=0x8000_0001, data_ready_i held 0 for 5 cycles after data_val_o -> data_o=2 and data_val_o stable throughout, data_ready_o=0; data_ready_i=1 -> one transfer, IDLE next cycle.
- Back-to-back words 0x0000_00F0 then 0x0F0F_0F0F with data_val_i held high, data_ready_i=1 -> results 4 then 16, in order, no word lost or duplicated; data_i toggled during COUNT has no effect.
- Assert srst_i for 1 cycle during COUNT (idx=2) of a 0xFFFF_FFFF word -> no data_val_o for that word; data_o=0, data_ready_o=1 next cycle; the following word 0x0000_0003 yields data_o=2.
- CHUNK=WIDTH=16, data_i=0xAAAA -> data_o=8 one cycle after accept; with BIT_POPULATION_COUNTER_MC_PARITY_EN defined, parity_o=0; for data_i=0x0007, data_o=3 and parity_o=1.
